// File: rtl/cla_pkg.sv
// Shared types, default geometry and flag helpers for the pipelined CLA adder/subtractor.
package cla_pkg;

   typedef enum logic {
      CLA_ADD = 1'b0,
      CLA_SUB = 1'b1
   } cla_op_e;

   localparam int CLA_WIDTH_DEF = 32;
   localparam int CLA_GROUP_DEF = 8;

   // Signed overflow: carry into the MSB disagrees with carry out of the MSB.
   function automatic logic cla_ovf(input logic c_msb_in, input logic c_out);
      return c_msb_in ^ c_out;
   endfunction

endpackage

// File: rtl/cla_group.sv
// Purely combinational GROUP-bit carry-lookahead block. Every internal carry is a
// flat sum of products of g/p/ci terms, so no carry ripples through the group.
module cla_group
   import cla_pkg::*;
#(
   parameter int GROUP = CLA_GROUP_DEF
) (
   input  logic [GROUP-1:0] a,
   input  logic [GROUP-1:0] b,
   input  logic             ci,
   output logic [GROUP-1:0] s,
   output logic             co,
   output logic             c_msb_in
);

   logic [GROUP-1:0] w_p;
   logic [GROUP-1:0] w_g;
   logic [GROUP:0]   w_c;

   // c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]ci, each term built from g/p/ci only.
   function automatic logic [GROUP:0] lookahead(input logic [GROUP-1:0] p,
                                                input logic [GROUP-1:0] g,
                                                input logic             cin);
      logic [GROUP:0] c;
      logic           prod;
      c    = '0;
      c[0] = cin;
      for (int i = 0; i < GROUP; i++) begin
         prod = 1'b1;
         for (int j = i; j >= 0; j--) begin
            c[i+1] = c[i+1] | (prod & g[j]);
            prod   = prod & p[j];
         end
         c[i+1] = c[i+1] | (prod & cin);
      end
      return c;
   endfunction

   assign w_p      = a ^ b;
   assign w_g      = a & b;
   assign w_c      = lookahead(w_p, w_g, ci);
   assign s        = w_p ^ w_c[GROUP-1:0];
   assign co       = w_c[GROUP];
   assign c_msb_in = w_c[GROUP-1];

endmodule

// File: rtl/cla_pipe_addsub.sv
// Pipelined carry-lookahead adder/subtractor. One GROUP-bit group is resolved per
// stage and its carry is registered into the next; latency is NGRP cycles, one
// beat per cycle, with a global stall driven by the output handshake.
// Optional zero/neg result flags are built when CLA_PIPE_FLAGS_EN is defined.
module cla_pipe_addsub
   import cla_pkg::*;
#(
   parameter int WIDTH = CLA_WIDTH_DEF,
   parameter int GROUP = CLA_GROUP_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
`ifdef CLA_PIPE_FLAGS_EN
   ,
   output logic             zero,
   output logic             neg
`endif
);

   localparam int NGRP = WIDTH / GROUP;

   cla_op_e          w_op;
   logic             w_adv;

   // Stage inputs (what each stage computes from) and stage outputs (what it registers).
   logic [WIDTH-1:0] w_a_in   [NGRP];
   logic [WIDTH-1:0] w_b_in   [NGRP];
   logic [WIDTH-1:0] w_sum_in [NGRP];
   logic             w_c_in   [NGRP];
   logic             w_vld_in [NGRP];
   logic [GROUP-1:0] w_s      [NGRP];
   logic             w_co     [NGRP];
   logic             w_cmsb   [NGRP];
   logic [WIDTH-1:0] w_sum_nxt[NGRP];

   logic [WIDTH-1:0] r_a   [NGRP];
   logic [WIDTH-1:0] r_b   [NGRP];
   logic [WIDTH-1:0] r_sum [NGRP];
   logic             r_c   [NGRP];
   logic             r_vld [NGRP];
   logic             r_ovf;
`ifdef CLA_PIPE_FLAGS_EN
   logic             r_zero;
   logic             r_neg;
`endif

   assign w_op     = cla_op_e'(sub);
   assign w_adv    = !r_vld[NGRP-1] || out_ready;
   assign in_ready = w_adv;

   // Stage input selection: ports feed stage 0, every later stage reads its predecessor.
   always_comb begin
      // NOTE: every element gets a default before any conditional write, so no latch can form.
      for (int k = 0; k < NGRP; k++) begin
         w_a_in[k]   = '0;
         w_b_in[k]   = '0;
         w_sum_in[k] = '0;
         w_c_in[k]   = 1'b0;
         w_vld_in[k] = 1'b0;
      end
      w_a_in[0]   = a;
      w_b_in[0]   = (w_op == CLA_SUB) ? ~b : b;
      w_c_in[0]   = (w_op == CLA_SUB) ? 1'b1 : cin;
      w_vld_in[0] = in_valid;
      for (int k = 1; k < NGRP; k++) begin
         w_a_in[k]   = r_a[k-1];
         w_b_in[k]   = r_b[k-1];
         w_sum_in[k] = r_sum[k-1];
         w_c_in[k]   = r_c[k-1];
         w_vld_in[k] = r_vld[k-1];
      end
   end

   for (genvar k = 0; k < NGRP; k++) begin : g_stage
      cla_group #(.GROUP(GROUP)) u_grp (
         .a        (w_a_in[k][k*GROUP +: GROUP]),
         .b        (w_b_in[k][k*GROUP +: GROUP]),
         .ci       (w_c_in[k]),
         .s        (w_s[k]),
         .co       (w_co[k]),
         .c_msb_in (w_cmsb[k])
      );
      // Merge this stage's slice into the partial result carried down the pipe.
      assign w_sum_nxt[k] = (w_sum_in[k] & ~({{(WIDTH-GROUP){1'b0}}, {GROUP{1'b1}}} << (k*GROUP)))
                          | (WIDTH'(w_s[k]) << (k*GROUP));
   end

   // Pipeline registers: all stages advance together on adv and hold otherwise.
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: data registers are cleared too, not only valid bits, so sum/cout/ovf read 0 out of reset.
         for (int k = 0; k < NGRP; k++) begin
            r_a[k]   <= '0;
            r_b[k]   <= '0;
            r_sum[k] <= '0;
            r_c[k]   <= 1'b0;
            r_vld[k] <= 1'b0;
         end
         r_ovf <= 1'b0;
`ifdef CLA_PIPE_FLAGS_EN
         r_zero <= 1'b0;
         r_neg  <= 1'b0;
`endif
      end else if (w_adv) begin
         // NOTE: non-blocking assignments let every stage sample its predecessor's old value.
         for (int k = 0; k < NGRP; k++) begin
            r_a[k]   <= w_a_in[k];
            r_b[k]   <= w_b_in[k];
            r_sum[k] <= w_sum_nxt[k];
            r_c[k]   <= w_co[k];
            r_vld[k] <= w_vld_in[k];
         end
         r_ovf <= cla_ovf(w_cmsb[NGRP-1], w_co[NGRP-1]);
`ifdef CLA_PIPE_FLAGS_EN
         r_zero <= (w_sum_nxt[NGRP-1] == '0);
         r_neg  <= w_sum_nxt[NGRP-1][WIDTH-1];
`endif
      end
   end

   assign out_valid = r_vld[NGRP-1];
   assign sum       = r_sum[NGRP-1];
   assign cout      = r_c[NGRP-1];
   assign ovf       = r_ovf;
`ifdef CLA_PIPE_FLAGS_EN
   assign zero      = r_zero;
   assign neg       = r_neg;
`endif

endmodule

// File: tb/tb_cla_pipe_addsub.sv
// Self-checking bench for cla_pipe_addsub (WIDTH=16, GROUP=4): a queue-based model
// of a+b+cin / a-b is checked on every output cycle, plus literal directed cases.
module tb_cla_pipe_addsub;

   localparam int W = 16;
   localparam int G = 4;
   localparam int N = W / G;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         sub;
   logic         cin;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] sum;
   logic         cout;
   logic         ovf;
`ifdef CLA_PIPE_FLAGS_EN
   logic         zero;
   logic         neg;
`endif

   cla_pipe_addsub #(.WIDTH(W), .GROUP(G)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .sub       (sub),
      .cin       (cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .ovf       (ovf)
`ifdef CLA_PIPE_FLAGS_EN
      ,
      .zero      (zero),
      .neg       (neg)
`endif
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [W-1:0] s;
      logic         c;
      logic         v;
   } res_t;

   res_t q[$];
   int   n_cmp  = 0;
   int   n_fail = 0;
   int   n_tx   = 0;
   int   n_rx   = 0;
   int   cyc    = 0;

   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: plain integer arithmetic and the sign rule for two's-complement overflow.
   function automatic res_t model(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                                  input logic ts, input logic tc);
      logic [W:0] full;
      res_t       r;
      if (ts) full = {1'b0, ta} - {1'b0, tb_v} + (W+1)'(1 << W); // a-b, bit W = no borrow
      else    full = {1'b0, ta} + {1'b0, tb_v} + (W+1)'(tc);
      r.s = full[W-1:0];
      r.c = full[W];
      if (ts) r.v = (ta[W-1] != tb_v[W-1]) && (r.s[W-1] != ta[W-1]);
      else    r.v = (ta[W-1] == tb_v[W-1]) && (r.s[W-1] != ta[W-1]);
      return r;
   endfunction

   // Scoreboard: checks handshake rule and head result every cycle, pops on drain, pushes on accept.
   always @(negedge clk) begin
      if (rst) begin
         n_tx -= q.size();
         q.delete();
      end else begin
         check("in_ready rule", in_ready, !out_valid || out_ready);
         if (out_valid) begin
            if (q.size() == 0) begin
               check("spurious out_valid", out_valid, 0);
            end else begin
               check("result", {sum, cout, ovf}, q[0]);
`ifdef CLA_PIPE_FLAGS_EN
               check("zero flag", zero, q[0].s == '0);
               check("neg flag", neg, q[0].s[W-1]);
`endif
               if (out_ready) begin
                  void'(q.pop_front());
                  n_rx++;
               end
            end
         end
         if (in_valid && in_ready) begin
            q.push_back(model(a, b, sub, cin));
            n_tx++;
         end
      end
   end

   // One isolated beat: checks latency, literal result and a one-cycle out_valid pulse.
   task automatic single(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic ts,
                         input logic tc, input logic [W-1:0] es, input logic ec, input logic ev);
      int n;
      a = ta; b = tb_v; sub = ts; cin = tc; in_valid = 1'b1; out_ready = 1'b1;
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
         in_valid = 1'b0;
      end while (!out_valid && n < 20);
      check("latency", n, N);
      check("single sum", sum, es);
      check("single cout", cout, ec);
      check("single ovf", ovf, ev);
      @(posedge clk); #1;
      check("single pulse", out_valid, 0);
   endtask

   // Present one beat and hold it until the block takes it.
   task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic ts, input logic tc);
      logic acc;
      int   guard;
      a = ta; b = tb_v; sub = ts; cin = tc; in_valid = 1'b1;
      guard = 0;
      do begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk); #1;
         guard++;
      end while (!acc && guard < 100);
      if (!acc) check("send timeout", acc, 1);
   endtask

   task automatic drain();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 50; i++) begin
         if (q.size() == 0 && !out_valid) break;
         @(posedge clk); #1;
      end
      check("drain empty", q.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int c0;
      rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; cin = 1'b0; out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // Idle after reset
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         check("idle out_valid", out_valid, 0);
         check("idle sum", sum, 0);
         check("idle in_ready", in_ready, 1);
      end
      check("idle cout", cout, 0);
      check("idle ovf", ovf, 0);

      // Directed literal cases
      single(16'h1234, 16'h0FCD, 1'b0, 1'b1, 16'h2202, 1'b0, 1'b0);
      single(16'h0000, 16'h0001, 1'b1, 1'b0, 16'hFFFF, 1'b0, 1'b0);
      single(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
      single(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
      single(16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1);

      // Back-to-back random beats at full throughput
      out_ready = 1'b1;
      c0 = cyc;
      for (int i = 0; i < 20; i++)
         send(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
      in_valid = 1'b0;
      check("b2b cycles", cyc - c0, 20);
      drain();

      // Backpressure mid-stream
      fork
         begin
            for (int i = 0; i < 30; i++)
               send(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
            in_valid = 1'b0;
         end
         begin
            repeat (8) @(posedge clk);
            #1 out_ready = 1'b0;
            repeat (5) begin
               @(negedge clk);
               check("stall in_ready", in_ready, 0);
               check("stall out_valid", out_valid, 1);
            end
            @(posedge clk); #1 out_ready = 1'b1;
         end
      join
      drain();

      // Random valid/ready traffic
      for (int i = 0; i < 300; i++) begin
         a = W'($urandom); b = W'($urandom); sub = 1'($urandom); cin = 1'($urandom);
         in_valid  = ($urandom % 4) != 0;
         out_ready = ($urandom % 3) != 0;
         @(posedge clk); #1;
      end
      drain();
      check("beats out vs in", n_rx, n_tx);

      // Reset with three beats in flight
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) send(W'($urandom), W'($urandom), 1'b0, 1'b0);
      in_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      check("rst out_valid", out_valid, 0);
      check("rst sum", sum, 0);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         check("post-rst out_valid", out_valid, 0);
      end
      check("beats after rst", n_rx, n_tx);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end

endmodule
